stack_drain: RTL and testbench

- Read-side controller for the LIFO stack. On command it pops up to N words and presents them, top of stack first, on a valid/ready output stream.
- Sits between the stack's rd/r_data/empty/underflow side and a downstream consumer, such as a serializer.
- Replaces hand-pulsed rd strobes with a flow-controlled drain engine.

---
 rtl/stack_pkg.sv | 12 +
 rtl/stack_drain.sv | 79 +++++++
 tb/tb_stack_drain.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared stack defaults, drain FSM state encoding and parity helper.
package stack_pkg;
  localparam int DEF_WORD_LEN = 8;
  localparam int DEF_WORD_SIZE = 4;
  localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, PRESENT = 2'd2, DONE = 2'd3;
  function automatic int cnt_w(input int word_size);
    return word_size + 1;
  endfunction
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/stack_drain.sv
// stack_drain: pops up to count words from the LIFO and streams them out over valid/ready.
// Optional STACK_DRAIN_PARITY_EN adds a registered even-parity output m_parity.
module stack_drain import stack_pkg::*; #(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int CNT_W = cnt_w(WORD_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    drained,
  output logic                err,
  output logic                stk_rd,
  input  logic [WORD_LEN-1:0] stk_r_data,
  input  logic                stk_empty,
  input  logic                stk_uf,
  output logic [WORD_LEN-1:0] m_data,
`ifdef STACK_DRAIN_PARITY_EN
  output logic                m_parity,
`endif
  output logic                m_valid,
  input  logic                m_ready
);
  logic [1:0] state, state_nx;
  logic [CNT_W-1:0] remaining;
  logic zero_mode, go, accept;
  assign go = !stk_empty && (zero_mode || remaining != '0);
  assign accept = state == IDLE && start;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CHECK : IDLE;
      CHECK:   state_nx = go ? PRESENT : DONE;
      PRESENT: state_nx = m_ready ? CHECK : PRESENT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    stk_rd = state == CHECK && go;
  end
  // Pop and capture happen on the same edge, so m_data holds the popped word through PRESENT.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      remaining <= '0;
      drained <= '0;
      zero_mode <= 1'b0;
      err <= 1'b0;
      m_data <= '0;
      m_valid <= 1'b0;
`ifdef STACK_DRAIN_PARITY_EN
      m_parity <= 1'b0;
`endif
    end else begin
      err <= accept ? 1'b0 : (busy && stk_uf) ? 1'b1 : err;
      if (accept) begin
        remaining <= count;
        drained <= '0;
        zero_mode <= count == '0;
      end
      if (stk_rd) begin
        m_data <= stk_r_data;
        m_valid <= 1'b1;
        drained <= drained + CNT_W'(1);
        remaining <= zero_mode ? remaining : remaining - CNT_W'(1);
`ifdef STACK_DRAIN_PARITY_EN
        m_parity <= parity(64'(stk_r_data));
`endif
      end
      if (state == PRESENT && m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_stack_drain.sv
// tb_stack_drain: directed checks of stack_drain against a behavioural LIFO model.
module tb_stack_drain;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [4:0] count = '0;
  logic busy, done, err, stk_rd, stk_empty, stk_uf, m_valid;
  logic m_ready = 1'b1;
  logic [4:0] drained;
  logic [7:0] stk_r_data, m_data;
`ifdef STACK_DRAIN_PARITY_EN
  logic m_parity;
`endif
  logic push_en = 1'b0, tb_rd = 1'b0, uf_force = 1'b0;
  logic [7:0] push_data = '0;
  logic [7:0] mem [16];
  logic [4:0] sp = '0;
  logic [7:0] got [16];
  int n, rds;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  stack_drain dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .busy(busy), .done(done),
    .drained(drained), .err(err), .stk_rd(stk_rd), .stk_r_data(stk_r_data),
    .stk_empty(stk_empty), .stk_uf(stk_uf), .m_data(m_data),
`ifdef STACK_DRAIN_PARITY_EN
    .m_parity(m_parity),
`endif
    .m_valid(m_valid), .m_ready(m_ready)
  );

  assign stk_empty = sp == '0;
  assign stk_r_data = stk_empty ? 8'h00 : mem[4'(sp - 5'd1)];
  assign stk_uf = ((stk_rd || tb_rd) && stk_empty) || uf_force;
  always @(posedge clk)
    if (push_en) begin
      mem[sp[3:0]] <= push_data;
      sp <= sp + 5'd1;
    end else if ((stk_rd || tb_rd) && !stk_empty) sp <= sp - 5'd1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clk) push_en = 1'b1; push_data = v;
    @(negedge clk) push_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk) check(tag, stk_r_data, exp); tb_rd = 1'b1;
    @(negedge clk) tb_rd = 1'b0;
  endtask

  task automatic start_drain(input logic [4:0] c);
    @(negedge clk) start = 1'b1; count = c;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    n = 0;
    rds = 0;
    while (!done && t < 100) begin
      if (stk_rd) rds++;
      if (m_valid && m_ready && n < 16) begin got[n] = m_data; n++; end
      @(negedge clk) t++;
    end
    check("done_seen", done, 1);
    @(negedge clk) check("done_pulse", done, 0);
  endtask

  initial begin
    logic stable;
    int t;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_drained", drained, 0);
    check("rst_rd", stk_rd, 0);
    reset = 1'b1;
    // count=3 from five words, then pop the leftovers by hand
    for (int i = 1; i <= 5; i++) push(8'(i));
    start_drain(5'd3);
    wait_done();
    check("t1_n", n, 3);
    check("t1_w0", got[0], 5);
    check("t1_w1", got[1], 4);
    check("t1_w2", got[2], 3);
    check("t1_drained", drained, 3);
    check("t1_rds", rds, 3);
    pop_check("t1_left2", 8'd2);
    pop_check("t1_left1", 8'd1);
    check("t1_empty", stk_empty, 1);
    // count=0 drains to empty
    for (int i = 1; i <= 4; i++) push(8'(i));
    start_drain(5'd0);
    n = 0;
    wait_done();
    check("t2_n", n, 4);
    check("t2_w0", got[0], 4);
    check("t2_w3", got[3], 1);
    check("t2_drained", drained, 4);
    check("t2_err", err, 0);
    check("t2_empty", stk_empty, 1);
    // count larger than contents stops on empty
    push(8'd1);
    push(8'd2);
    start_drain(5'd8);
    wait_done();
    check("t3_n", n, 2);
    check("t3_w0", got[0], 2);
    check("t3_w1", got[1], 1);
    check("t3_drained", drained, 2);
    // stalled consumer: data held, single pop, underflow sets sticky err
    push(8'd7);
    m_ready = 1'b0;
    start_drain(5'd1);
    rds = stk_rd ? 1 : 0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) stable &= m_valid && m_data == 8'd7;
      if (stk_rd) rds++;
      uf_force = i == 4;
    end
    uf_force = 1'b0;
    check("t4_stable", stable, 1);
    check("t4_busy", busy, 1);
    m_ready = 1'b1;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk) t++;
      if (stk_rd) rds++;
    end
    check("t4_done", done, 1);
    check("t4_rds", rds, 1);
    check("t4_drained", drained, 1);
    check("t4_err", err, 1);
    @(negedge clk) check("t4_err_sticky", err, 1);
    // reset while word 4 is presented
    for (int i = 1; i <= 6; i++) push(8'(i));
    start_drain(5'd0);
    check("t5_err_clr", err, 0);
    t = 0;
    while (!(m_valid && m_data == 8'd4) && t < 50) begin
      @(negedge clk) t++;
    end
    check("t5_reach4", m_data, 4);
    reset = 1'b0;
    #1;
    check("t5_valid0", m_valid, 0);
    check("t5_data0", m_data, 0);
    check("t5_busy0", busy, 0);
    check("t5_drained0", drained, 0);
    @(negedge clk) reset = 1'b1;
    start_drain(5'd0);
    wait_done();
    check("t5_n", n, 3);
    check("t5_w0", got[0], 3);
    check("t5_w2", got[2], 1);
    // empty stack at start
    start_drain(5'd5);
    check("t6_rd", stk_rd, 0);
    check("t6_busy", busy, 1);
    @(negedge clk) check("t6_done", done, 1);
    check("t6_drained", drained, 0);
    @(negedge clk) check("t6_idle", busy, 0);
    // start held high while busy is ignored
    for (int i = 1; i <= 3; i++) push(8'(i));
    start_drain(5'd1);
    start = 1'b1;
    count = 5'd0;
    wait_done();
    start = 1'b0;
    check("t7_n", n, 1);
    check("t7_w0", got[0], 3);
    check("t7_drained", drained, 1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk) stable &= !busy && !done;
    check("t7_no_restart", stable, 1);
    check("t7_top", stk_r_data, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
